// File: rtl/parity_sched_pkg.sv
// Shared types and helpers for the round-robin serial parity scheduler.
package parity_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        SHIFT  = 2'd2,
        REPORT = 2'd3
    } sched_state_e;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } engine_state_e;

    // Round-robin pick over up to 16 requesters: the nearest set bit after last_grant wins.
    // Scanning offsets from far to near lets the closest candidate overwrite the others.
    function automatic logic [3:0] rr_pick(input logic [15:0] req,
                                           input logic [3:0]  last_grant,
                                           input logic [4:0]  num_req);
        logic [3:0] win;
        logic [3:0] idx;
        win = last_grant;
        for (int i = 16; i >= 1; i--) begin
            if (i <= int'(num_req)) begin
                idx = 4'((int'(last_grant) + i) % int'(num_req));
                if (req[idx]) begin
                    win = idx;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/parity_check_scheduler_if.sv
// Request/result bus between client blocks and the parity scheduler.
interface parity_check_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic                      busy;
    logic                      done;
    logic [ID_W-1:0]           done_id;
    logic                      parity_odd;

    modport master (output req, req_data, input ack, busy, done, done_id, parity_odd);
    modport slave  (input req, req_data, output ack, busy, done, done_id, parity_odd);
endinterface

// File: rtl/serial_parity_core.sv
// Bit-serial odd-ones parity engine; the only holder of the EVEN/ODD state.
module serial_parity_core
    import parity_sched_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic bit_in,
    input  logic bit_en,
    output logic odd
);

    engine_state_e state_q;
    engine_state_e state_d;

    // Next engine state: a shifted-in one toggles, a zero holds.
    always_comb begin
        state_d = state_q;
        if (bit_en && bit_in) begin
            state_d = (state_q == ODD) ? EVEN : ODD;
        end else begin
            state_d = state_q;
        end
    end

    // Engine state register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EVEN;
        end else begin
            state_q <= state_d;
        end
    end

    assign odd = (state_q == ODD);

endmodule

// File: rtl/parity_check_scheduler.sv
// Round-robin scheduler sharing one serial parity engine between NUM_REQ requesters.
module parity_check_scheduler
    import parity_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    parity_check_scheduler_if.slave   bus
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DATA_W + 1);

    sched_state_e        state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [15:0]         req_ext_s;
    logic [ID_W-1:0]     winner_s;
    logic                eng_reset_s;
    logic                eng_en_s;
    logic                eng_bit_s;
    logic                eng_odd_s;

    // Arbitration candidate; only acted upon while IDLE.
    always_comb begin
        req_ext_s                = 16'd0;
        req_ext_s[NUM_REQ-1:0]   = bus.req;
        winner_s                 = ID_W'(rr_pick(req_ext_s, 4'(last_grant_q), 5'(NUM_REQ)));
    end

    // Next-state and datapath updates for the scheduler FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        word_d       = word_q;
        ack_d        = {NUM_REQ{1'b0}};
        case (state_q)
            IDLE: begin
                if (bus.req != {NUM_REQ{1'b0}}) begin
                    state_d      = CLEAR;
                    last_grant_d = winner_s;
                    id_d         = winner_s;
                    word_d       = bus.req_data[winner_s*DATA_W +: DATA_W];
                    ack_d        = NUM_REQ'(1) << winner_s;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                state_d = SHIFT;
                cnt_d   = {CNT_W{1'b0}};
            end
            SHIFT: begin
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = REPORT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scheduler registers; last_grant resets to the top ID so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= {ID_W{1'b0}};
            word_q       <= {DATA_W{1'b0}};
            ack_q        <= {NUM_REQ{1'b0}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            word_q       <= word_d;
            ack_q        <= ack_d;
        end
    end

    assign eng_reset_s = reset | (state_q == CLEAR);
    assign eng_en_s    = (state_q == SHIFT);
    assign eng_bit_s   = |(word_q & (DATA_W'(1) << cnt_q));

    serial_parity_core u_core (
        .clk    (clk),
        .reset  (eng_reset_s),
        .bit_in (eng_bit_s),
        .bit_en (eng_en_s),
        .odd    (eng_odd_s)
    );

    assign bus.ack        = ack_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == REPORT);
    assign bus.done_id    = (state_q == REPORT) ? id_q : {ID_W{1'b0}};
    assign bus.parity_odd = (state_q == REPORT) & eng_odd_s;

endmodule

// File: tb/tb_parity_check_scheduler.sv
// Directed self-checking bench for parity_check_scheduler (NUM_REQ=4, DATA_W=8).
module tb_parity_check_scheduler;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    parity_check_scheduler_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

    parity_check_scheduler #(.NUM_REQ(4), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [7:0] word;
        logic [1:0] exp_id;
        logic       exp_odd;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called in the IDLE cycle in which the request is presented (cycle 0).
    task automatic do_txn(input string nm, input logic [1:0] exp_id, input logic exp_odd,
                          input logic [3:0] req_after_ack, input logic [3:0] midshift_set);
        int bad;
        bad = 0;
        step();
        check({nm, ".ack"}, 32'(bus.ack), 32'(4'b0001 << exp_id));
        check({nm, ".busy1"}, 32'(bus.busy), 32'd1);
        bus.req = req_after_ack;
        for (int k = 2; k <= 9; k++) begin
            step();
            if (k == 5) bus.req = bus.req | midshift_set;
            if (bus.ack !== 4'b0000 || bus.done !== 1'b0 || bus.busy !== 1'b1) bad++;
        end
        check({nm, ".shift_quiet"}, 32'(bad), 32'd0);
        step();
        check({nm, ".done"}, 32'(bus.done), 32'd1);
        check({nm, ".done_id"}, 32'(bus.done_id), 32'(exp_id));
        check({nm, ".parity_odd"}, 32'(bus.parity_odd), 32'(exp_odd));
        step();
        check({nm, ".idle"}, {29'd0, bus.busy, bus.done, bus.parity_odd}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{req: 4'b0001, word: 8'h07, exp_id: 2'd0, exp_odd: 1'b1};
        vecs[1] = '{req: 4'b0100, word: 8'h00, exp_id: 2'd2, exp_odd: 1'b0};
        vecs[2] = '{req: 4'b0100, word: 8'hFF, exp_id: 2'd2, exp_odd: 1'b0};
        vecs[3] = '{req: 4'b0100, word: 8'h80, exp_id: 2'd2, exp_odd: 1'b1};
        vecs[4] = '{req: 4'b0010, word: 8'hAA, exp_id: 2'd1, exp_odd: 1'b0};
        vecs[5] = '{req: 4'b0010, word: 8'hAB, exp_id: 2'd1, exp_odd: 1'b1};

        reset        = 1'b1;
        bus.req      = 4'b0000;
        bus.req_data = 32'd0;
        step();
        step();
        check("rst.ack", 32'(bus.ack), 32'd0);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.done_id", 32'(bus.done_id), 32'd0);
        check("rst.parity_odd", 32'(bus.parity_odd), 32'd0);

        // All four requesting continuously: rotation 0,1,2,3,0.
        reset        = 1'b0;
        bus.req      = 4'b1111;
        bus.req_data = {8'h08, 8'h04, 8'h02, 8'h01};
        do_txn("rr0", 2'd0, 1'b1, 4'b1111, 4'b0000);
        do_txn("rr1", 2'd1, 1'b1, 4'b1111, 4'b0000);
        do_txn("rr2", 2'd2, 1'b1, 4'b1111, 4'b0000);
        do_txn("rr3", 2'd3, 1'b1, 4'b1111, 4'b0000);
        do_txn("rr4", 2'd0, 1'b1, 4'b0000, 4'b0000);

        for (int v = 0; v < 6; v++) begin
            bus.req      = vecs[v].req;
            bus.req_data = {4{vecs[v].word}};
            do_txn($sformatf("vec%0d", v), vecs[v].exp_id, vecs[v].exp_odd, 4'b0000, 4'b0000);
        end

        // last_grant is now 1: 1010 grants 3 then 1; requester 2 rising mid-SHIFT waits.
        bus.req      = 4'b1010;
        bus.req_data = {8'h01, 8'h07, 8'h03, 8'h00};
        do_txn("pair3", 2'd3, 1'b1, 4'b1010, 4'b0000);
        do_txn("pair1", 2'd1, 1'b0, 4'b1010, 4'b0100);
        do_txn("late2", 2'd2, 1'b1, 4'b0000, 4'b0000);

        // Reset in SHIFT cycle 4 together with a pending request.
        bus.req      = 4'b0001;
        bus.req_data = {8'h00, 8'h00, 8'h0F, 8'hFF};
        step();
        check("mid.ack", 32'(bus.ack), 32'd1);
        bus.req = 4'b0000;
        step();
        step();
        step();
        reset   = 1'b1;
        bus.req = 4'b0011;
        step();
        check("mid.outs_zero", {26'd0, bus.ack, bus.busy, bus.done, bus.parity_odd}, 32'd0);
        check("mid.done_id", 32'(bus.done_id), 32'd0);
        step();
        check("mid.no_ack_in_reset", {27'd0, bus.ack, bus.busy}, 32'd0);
        reset = 1'b0;
        do_txn("post_rst", 2'd0, 1'b0, 4'b0000, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
